// File: rtl/arb_out_buffer_pkg.sv
// Shared types and widths for the arbiter output buffer.
package arb_out_buffer_pkg;

  localparam int DATA_W  = 32;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    STREAM   = 2'd0,
    THROTTLE = 2'd1,
    STALL    = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/arb_out_buffer_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read
// so it maps onto distributed RAM.
module arb_out_buffer_mem
  import arb_out_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk_sys,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/arb_out_buffer.sv
// Elastic buffer from the readout arbiter to the external FIFO, paced by the
// FIFO full/near-full flags. Optional stall counter: define ARB_BUF_STALL_CNT_EN.
//
// state    | meaning
// STREAM   | forward one word per cycle
// THROTTLE | forward one word every second cycle (external FIFO near full)
// STALL    | forward nothing (external FIFO full)
module arb_out_buffer
  import arb_out_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic                     WRITE_IN,
  input  logic [DATA_W-1:0]        DATA_IN,
  output logic                     READY_OUT,
  input  logic                     FIFO_FULL,
  input  logic                     FIFO_NEAR_FULL,
  output logic                     FIFO_WRITE,
  output logic [DATA_W-1:0]        FIFO_DATA,
  output logic [$clog2(DEPTH):0]   FILL_LEVEL,
  output logic                     ALMOST_FULL,
  input  logic                     CLR_STALL_CNT,
  output logic [STALL_W-1:0]       STALL_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  fsm_state_t        state, next_state;
  logic              toggle;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rd_data;
  logic              gate, acc, rd;

  assign READY_OUT   = BUS_RST_N && (count != FULL_CNT);
  assign acc         = WRITE_IN && READY_OUT;
  assign FILL_LEVEL  = count;
  assign ALMOST_FULL = (count >= AFULL_CNT);

  always_comb begin
    gate = 1'b0;
    case (state)
      STREAM:   gate = 1'b1;
      THROTTLE: gate = toggle;
      default:  gate = 1'b0;
    endcase
  end

  assign rd = (count != '0) && gate;

  always_comb begin
    if (FIFO_FULL)           next_state = STALL;
    else if (FIFO_NEAR_FULL) next_state = THROTTLE;
    else                     next_state = STREAM;
  end

  arb_out_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_sys (BUS_CLK),
    .wr_en   (acc),
    .wr_addr (wr_ptr),
    .wr_data (DATA_IN),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state      <= STREAM;
      toggle     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      FIFO_WRITE <= 1'b0;
      FIFO_DATA  <= '0;
    end else begin
      state <= next_state;
      // toggle only runs while THROTTLE persists, so each entry starts with a gap cycle
      toggle     <= (state == THROTTLE && next_state == THROTTLE) ? ~toggle : 1'b0;
      FIFO_WRITE <= rd;
      if (rd) begin
        FIFO_DATA <= rd_data;
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      case ({acc, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_BUF_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)
      stall_cnt <= '0;
    else if (CLR_STALL_CNT)
      stall_cnt <= '0;
    else if (state != STREAM && count != '0 && stall_cnt != {STALL_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign STALL_CNT = stall_cnt;
`else
  logic unused_clr_stall;
  assign unused_clr_stall = CLR_STALL_CNT;
  assign STALL_CNT        = '0;
`endif

endmodule

// File: tb/tb_arb_out_buffer.sv
// Bench for arb_out_buffer: a queue-based reference model predicts every cycle.
module tb_arb_out_buffer;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready;
  logic        full = 1'b0;
  logic        nf = 1'b0;
  logic        fifo_write;
  logic [31:0] fifo_data;
  logic [4:0]  fill;
  logic        afull;
  logic        clr = 1'b0;
  logic [15:0] stall;

  int checks = 0;
  int passed = 0;

  // reference model: queue of buffered words plus pacing mode seen last cycle
  logic [31:0] mq[$];
  int          mode = 0;      // 0 stream, 1 throttle, 2 stall
  int          thr_run = 0;   // consecutive cycles already spent throttling
  logic [31:0] m_data = '0;
  logic        m_write = 1'b0;
  int          m_stall = 0;

  arb_out_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .WRITE_IN       (write_in),
    .DATA_IN        (data_in),
    .READY_OUT      (ready),
    .FIFO_FULL      (full),
    .FIFO_NEAR_FULL (nf),
    .FIFO_WRITE     (fifo_write),
    .FIFO_DATA      (fifo_data),
    .FILL_LEVEL     (fill),
    .ALMOST_FULL    (afull),
    .CLR_STALL_CNT  (clr),
    .STALL_CNT      (stall)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mode = 0; thr_run = 0; m_data = '0; m_write = 1'b0; m_stall = 0;
  endtask

  // drive one cycle of inputs, advance the model, return 1 ns after the edge
  task automatic step(input logic w, input logic [31:0] d, input logic f,
                      input logic n, input logic c);
    int sz;
    int nmode;
    bit rdm;
    write_in = w; data_in = d; full = f; nf = n; clr = c;
    sz  = mq.size();
    rdm = (sz != 0) && (mode == 0 || (mode == 1 && (thr_run % 2) == 1));
    m_write = rdm;
    if (rdm) m_data = mq.pop_front();
    if (w && sz < DEPTH) mq.push_back(d);
`ifdef ARB_BUF_STALL_CNT_EN
    if (c) m_stall = 0;
    else if (mode != 0 && sz != 0 && m_stall < 65535) m_stall++;
`endif
    nmode = f ? 2 : (n ? 1 : 0);
    thr_run = (nmode == 1 && mode == 1) ? thr_run + 1 : 0;
    mode = nmode;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ready !== 1'b0 || fifo_write !== 1'b0 || fifo_data !== 32'h0 ||
        fill !== 5'd0 || afull !== 1'b0 || stall !== 16'h0)
      $display("FAIL reset_values: ready=%b wr=%b data=%h fill=%0d afull=%b stall=%0d, required 0/0/0/0/0/0",
               ready, fifo_write, fifo_data, fill, afull, stall);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", ready);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_burst();
    int nw = 0;
    for (int i = 0; i < 23; i++) begin
      step(i < 20, 32'(i), 1'b0, 1'b0, 1'b0);
      if (fifo_write) nw++;
      checks++;
      if (fifo_write !== m_write || fifo_data !== m_data || ready !== 1'b1)
        $display("FAIL burst_cycle%0d: wr=%b data=%h ready=%b, required wr=%b data=%h ready=1",
                 i, fifo_write, fifo_data, ready, m_write, m_data);
      else passed++;
    end
    checks++;
    if (nw !== 20) $display("FAIL burst_count: got %0d writes required 20", nw);
    else passed++;
  endtask

  task automatic test_full();
    int nw = 0;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (fifo_write !== m_write || fill !== 5'(mq.size()) ||
          ready !== (mq.size() != DEPTH) || afull !== (mq.size() >= AFULL) ||
          stall !== 16'(m_stall))
        $display("FAIL full_fill%0d: wr=%b fill=%0d ready=%b afull=%b stall=%0d, required wr=%b fill=%0d afull=%b stall=%0d",
                 i, fifo_write, fill, ready, afull, stall, m_write, mq.size(),
                 mq.size() >= AFULL, m_stall);
      else passed++;
    end
    checks++;
    if (fill !== 5'd16 || ready !== 1'b0 || afull !== 1'b1)
      $display("FAIL full_level: fill=%0d ready=%b afull=%b, required 16/0/1", fill, ready, afull);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (fifo_write) nw++;
      checks++;
      if (fifo_write !== m_write || fifo_data !== m_data)
        $display("FAIL full_drain%0d: wr=%b data=%h, required wr=%b data=%h",
                 i, fifo_write, fifo_data, m_write, m_data);
      else passed++;
    end
    checks++;
    if (nw !== 16) $display("FAIL full_drain_count: got %0d writes required 16", nw);
    else passed++;
  endtask

  task automatic test_near_full();
    int nw = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (fifo_write) nw++;
      checks++;
      if (fifo_write !== m_write || fifo_data !== m_data || fifo_write !== 1'(i % 2))
        $display("FAIL throttle_cycle%0d: wr=%b data=%h, required wr=%b data=%h",
                 i, fifo_write, fifo_data, m_write, m_data);
      else passed++;
    end
    checks++;
    if (nw !== 8 || fill !== 5'd0)
      $display("FAIL throttle_count: got %0d writes fill=%0d, required 8 writes fill=0", nw, fill);
    else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_write !== 1'b1) $display("FAIL reset_mid_inflight: wr=%b required 1", fifo_write);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_write !== 1'b0 || fifo_data !== 32'h0 || fill !== 5'd0 ||
        ready !== 1'b0 || afull !== 1'b0 || stall !== 16'h0)
      $display("FAIL reset_mid_values: wr=%b data=%h fill=%0d ready=%b afull=%b stall=%0d, required all 0",
               fifo_write, fifo_data, fill, ready, afull, stall);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hABCD_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hABCD_0002, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_write !== 1'b1 || fifo_data !== 32'hABCD_0001 || fifo_data !== m_data)
      $display("FAIL reset_mid_first_word: wr=%b data=%h, required wr=1 data=abcd0001",
               fifo_write, fifo_data);
    else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_write !== 1'b1 || fifo_data !== 32'hABCD_0002 || fill !== 5'd0)
      $display("FAIL reset_mid_second_word: wr=%b data=%h fill=%0d, required 1/abcd0002/0",
               fifo_write, fifo_data, fill);
    else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef ARB_BUF_STALL_CNT_EN
  task automatic test_stall_cnt();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (stall !== 16'd0) $display("FAIL stall_clear1: got %0d required 0", stall);
    else passed++;
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (stall !== 16'd100 || stall !== 16'(m_stall))
      $display("FAIL stall_count: got %0d required 100", stall);
    else passed++;
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (stall !== 16'd0) $display("FAIL stall_clear2: got %0d required 0", stall);
    else passed++;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic        w, f, n, c;
    logic [31:0] d;
    for (int i = 0; i < 10000; i++) begin
      w = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) == 0);
      n = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 49) == 0);
      d = $urandom;
      step(w, d, f, n, c);
      checks++;
      if (fifo_write !== m_write || fifo_data !== m_data || fill !== 5'(mq.size()) ||
          ready !== (mq.size() != DEPTH) || afull !== (mq.size() >= AFULL) ||
          stall !== 16'(m_stall) || fill > 5'd16)
        $display("FAIL random_cycle%0d: wr=%b data=%h fill=%0d ready=%b afull=%b stall=%0d, required wr=%b data=%h fill=%0d stall=%0d",
                 i, fifo_write, fifo_data, fill, ready, afull, stall,
                 m_write, m_data, mq.size(), m_stall);
      else passed++;
    end
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fill !== 5'd0 || fifo_write !== 1'b0)
      $display("FAIL random_drain: fill=%0d wr=%b, required 0/0", fill, fifo_write);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_full();
    test_near_full();
    test_reset_mid();
`ifdef ARB_BUF_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/arb_out_buffer.md
# arb_out_buffer

Elastic buffer between the readout arbiter output and the external data FIFO (SiTCP/USB path). It accepts 32-bit words from the arbiter under the READY/WRITE handshake, stores them in a DEPTH-word circular buffer and forwards them to the external FIFO. A three-state throttle FSM paces forwarding from the external FIFO_FULL and FIFO_NEAR_FULL flags, so no word is ever dropped.

## Interface
Parameters:
- DEPTH, 16, buffer depth in words; power of two, ≥4.
- AFULL_LEVEL, 12, fill level at or above which ALMOST_FULL asserts; 1..DEPTH.

Ports:
- BUS_CLK  in  1  single clock for the whole block (the bus clock domain).
- BUS_RST_N  in  1  reset; asynchronous assert, active-low.
- WRITE_IN  in  1  word valid from the arbiter.
- DATA_IN  in  32  word from the arbiter.
- READY_OUT  out  1  buffer can accept a word; drives the arbiter's ready input.
- FIFO_FULL  in  1  external FIFO full.
- FIFO_NEAR_FULL  in  1  external FIFO near full.
- FIFO_WRITE  out  1  one-cycle write strobe to the external FIFO.
- FIFO_DATA  out  32  word to the external FIFO; valid with FIFO_WRITE.
- FILL_LEVEL  out  clog2(DEPTH)+1  words currently buffered.
- ALMOST_FULL  out  1  FILL_LEVEL ≥ AFULL_LEVEL.
- CLR_STALL_CNT  in  1  single-cycle clear of STALL_CNT.
- STALL_CNT  out  16  saturating stall-cycle counter (see Configuration).

## Operation
- Accept: a word is accepted when WRITE_IN && READY_OUT.
  - READY_OUT = (FILL_LEVEL != DEPTH), combinational from the registered count.
  - There is no bypass when full: a read in the same cycle does not raise READY_OUT.
- Read enable: rd = (FILL_LEVEL != 0) && gate. The value of gate depends on the FSM state:
  - STREAM: gate = 1.
  - THROTTLE: gate = the toggle bit. The toggle bit flips every cycle in THROTTLE, giving one read per two cycles, and clears on leaving THROTTLE.
  - STALL: gate = 0.
- FSM next state, evaluated every cycle; FULL has priority over NEAR_FULL:
  - FIFO_FULL → STALL.
  - else FIFO_NEAR_FULL → THROTTLE.
  - else → STREAM.
  - Any state may move to any other state in one cycle.
- Gating uses the current state, so the flags take effect one cycle after they are sampled. The external FIFO must absorb up to 2 words after asserting FIFO_FULL.
- Count update: +1 on accept only, −1 on read only, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
  - FILL_LEVEL never exceeds DEPTH and never underflows.
- Output: on rd, FIFO_DATA is loaded with mem[rd_ptr] and FIFO_WRITE is registered high for one cycle. Otherwise FIFO_WRITE = 0 and FIFO_DATA holds its last value.
- Word order is strictly preserved.

## Timing
- Reset values:
  - READY_OUT = 0 while BUS_RST_N is low, then 1.
  - FIFO_WRITE = 0, FIFO_DATA = 0, FILL_LEVEL = 0, ALMOST_FULL = 0, STALL_CNT = 0.
  - FSM = STREAM, pointers = 0, toggle bit = 0.
- Latency: a word accepted at edge n into an empty buffer in STREAM reaches FIFO_DATA with FIFO_WRITE high after edge n+1, so it is presented 1 cycle after acceptance.
- Throughput:
  - STREAM: 1 word/cycle sustained, in and out.
  - THROTTLE: 1 word per 2 cycles out.
- Reset mid-operation: all buffered words are discarded and an in-flight FIFO_WRITE is cleared asynchronously.
- Simultaneous accept and read at FILL_LEVEL = 1: the count stays at 1 and the new word is read next.

## Configuration
- Macro ARB_BUF_STALL_CNT_EN.
  - Defined: STALL_CNT increments each cycle in which FSM != STREAM and FILL_LEVEL != 0. It saturates at 16'hFFFF. CLR_STALL_CNT has priority over increment and zeroes it on the next edge.
  - Undefined: STALL_CNT is tied to 0, CLR_STALL_CNT is ignored, and no counter logic is synthesised.

## Structure
- Package arb_out_buffer_pkg holds:
  - the FSM state enum (STREAM, THROTTLE, STALL);
  - the data word width constant (32);
  - the STALL_CNT width constant (16).
- Sub-module arb_out_buffer_mem: simple dual-port DEPTH×32 memory with a synchronous write port and an asynchronous read port (distributed RAM). Pointers, count, FSM and output registers stay in the top module.

## Test plan
- Reset, then a burst of 20 words 0x00..0x13 with the FIFO flags low → FIFO_WRITE for 20 consecutive cycles, in order, each word 1 cycle after its accept; READY_OUT never drops.
- FIFO_FULL held high, 20 words offered → 16 accepted, READY_OUT low at FILL_LEVEL=16, ALMOST_FULL from the 12th word, no FIFO_WRITE after the 2-cycle grace. On release, 16 words are output in order.
- FIFO_NEAR_FULL held high with 8 words buffered → FIFO_WRITE on alternate cycles, 8 writes over 16 cycles.
- BUS_RST_N pulsed low with 10 words buffered → outputs immediately reach reset values; post-reset, the first output word is the first word written after reset.
- With ARB_BUF_STALL_CNT_EN defined: 100 cycles of FIFO_FULL with data buffered → STALL_CNT = 100. CLR_STALL_CNT → 0 on the next cycle.
- Random WRITE_IN and random flags for 10k cycles → scoreboard shows no loss, no duplication, no reordering; FILL_LEVEL stays within 0..16.
